stream_downsizer: RTL and testbench



---
 rtl/stream_downsizer.sv | 111 +++++++++++
 tb/tb_stream_downsizer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_downsizer.sv
// stream_downsizer: splits IN_DW-bit stream words into OUT_DW-bit chunks on a narrower valid/ready stream.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stream_s_*        input word stream (data, valid, ready)
//   stream_s_keep_i   per-chunk keep mask, natural chunk order (only with STREAM_DOWNSIZER_KEEP_EN)
//   stream_m_*        output chunk stream (data, valid, ready)
//   busy_o            high while a word is held
//
// Optional feature macro: STREAM_DOWNSIZER_KEEP_EN (chunks with keep = 0 are skipped).
module stream_downsizer #(
    parameter int IN_DW      = 32,
    parameter int OUT_DW     = 8,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IN_DW-1:0]          stream_s_data_i,
    input  logic                      stream_s_valid_i,
`ifdef STREAM_DOWNSIZER_KEEP_EN
    input  logic [IN_DW/OUT_DW-1:0]   stream_s_keep_i,
`endif
    output logic                      stream_s_ready_o,
    output logic [OUT_DW-1:0]         stream_m_data_o,
    output logic                      stream_m_valid_o,
    input  logic                      stream_m_ready_i,
    output logic                      busy_o
);
    localparam int RATIO = IN_DW / OUT_DW;
    localparam int IW    = RATIO > 1 ? $clog2(RATIO) : 1;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [IN_DW-1:0] data_q;
    // Masks are kept in emission order: bit p says whether the p-th emitted chunk is kept.
    logic [RATIO-1:0] mask_q;
    logic [RATIO-1:0] in_mask;
    logic [IW-1:0]    nxt_idx;
    logic             nxt_found;
    logic [IW-1:0]    ld_idx;
    logic             ld_found;
    logic             load;
    int               sel;

`ifdef STREAM_DOWNSIZER_KEEP_EN
    always_comb begin
        in_mask = '0;
        for (int k = 0; k < RATIO; k++)
            in_mask[k] = stream_s_keep_i[BIG_ENDIAN != 0 ? RATIO-1-k : k];
    end
`else
    assign in_mask = '1;
    assign mask_q  = '1;
`endif

    // Next kept position after idx, and first kept position of the incoming word.
    always_comb begin
        nxt_idx   = '0;
        nxt_found = 1'b0;
        ld_idx    = '0;
        ld_found  = 1'b0;
        for (int p = RATIO-1; p >= 0; p--) begin
            if (mask_q[p] && p > int'(idx)) begin
                nxt_found = 1'b1;
                nxt_idx   = IW'(p);
            end
            if (in_mask[p]) begin
                ld_found = 1'b1;
                ld_idx   = IW'(p);
            end
        end
    end

    always_comb begin
        sel             = BIG_ENDIAN != 0 ? RATIO-1-int'(idx) : int'(idx);
        stream_m_data_o = '0;
        for (int k = 0; k < RATIO; k++)
            if (k == sel) stream_m_data_o = data_q[k*OUT_DW +: OUT_DW];
    end

    // Ready combinationally follows stream_m_ready_i on the last chunk so words stream with no bubble.
    assign stream_s_ready_o = (state == EMPTY) || (state == FULL && !nxt_found && stream_m_ready_i);
    assign load             = stream_s_valid_i && stream_s_ready_o && ld_found;
    assign stream_m_valid_o = (state == FULL);
    assign busy_o           = (state == FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= EMPTY;
            idx    <= '0;
            data_q <= '0;
`ifdef STREAM_DOWNSIZER_KEEP_EN
            mask_q <= '0;
`endif
        end else if (state == FULL && stream_m_ready_i && nxt_found) begin
            idx <= nxt_idx;
        end else if (load) begin
            state  <= FULL;
            idx    <= ld_idx;
            data_q <= stream_s_data_i;
`ifdef STREAM_DOWNSIZER_KEEP_EN
            mask_q <= in_mask;
`endif
        end else if (state == FULL && stream_m_ready_i) begin
            state <= EMPTY;
            idx   <= '0;
        end
    end
endmodule

// File: tb/tb_stream_downsizer.sv
// tb_stream_downsizer: directed self-checking bench for stream_downsizer (little- and big-endian instances).
module tb_stream_downsizer;
    logic        clk;
    logic        rst_n;
    logic [31:0] s_data;
    logic        s_valid;
    logic        m_ready;
    logic [3:0]  s_keep;
    logic        s_ready,  m_valid,  busy;
    logic [7:0]  m_data;
    logic        s_ready2, m_valid2, busy2;
    logic [7:0]  m_data2;
    int          tests;
    int          fails;

    stream_downsizer #(.IN_DW(32), .OUT_DW(8), .BIG_ENDIAN(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .stream_s_data_i(s_data), .stream_s_valid_i(s_valid),
`ifdef STREAM_DOWNSIZER_KEEP_EN
        .stream_s_keep_i(s_keep),
`endif
        .stream_s_ready_o(s_ready),
        .stream_m_data_o(m_data), .stream_m_valid_o(m_valid), .stream_m_ready_i(m_ready),
        .busy_o(busy)
    );

    stream_downsizer #(.IN_DW(32), .OUT_DW(8), .BIG_ENDIAN(1)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .stream_s_data_i(s_data), .stream_s_valid_i(s_valid),
`ifdef STREAM_DOWNSIZER_KEEP_EN
        .stream_s_keep_i(s_keep),
`endif
        .stream_s_ready_o(s_ready2),
        .stream_m_data_o(m_data2), .stream_m_valid_o(m_valid2), .stream_m_ready_i(m_ready),
        .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; s_keep = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset: valid=%b busy=%b ready=%b, want 0 0 1", m_valid, busy, s_ready);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_single;
        logic [7:0] e [4];
        e[0] = 8'h11; e[1] = 8'h22; e[2] = 8'h33; e[3] = 8'h44;
        @(negedge clk);
        s_data = 32'h44332211; s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            tests++;
            if (m_valid !== 1'b1 || m_data !== e[i] || s_ready !== (i == 3)) begin
                fails++;
                $display("FAIL single chunk %0d: valid=%b data=%h ready=%b, want 1 %h %b",
                         i, m_valid, m_data, s_ready, e[i], i == 3);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single drain: valid=%b ready=%b busy=%b, want 0 1 0", m_valid, s_ready, busy);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e [8];
        e[0] = 8'hA0; e[1] = 8'hA1; e[2] = 8'hA2; e[3] = 8'hA3;
        e[4] = 8'hB0; e[5] = 8'hB1; e[6] = 8'hB2; e[7] = 8'hB3;
        @(negedge clk);
        s_data = 32'hA3A2A1A0; s_valid = 1'b1; m_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            s_data = 32'hB3B2B1B0;
            if (c == 8) s_valid = 1'b0;
            #1;
            tests++;
            if (m_valid !== 1'b1 || m_data !== e[c-1] || s_ready !== (c == 4 || c == 8)) begin
                fails++;
                $display("FAIL b2b cycle %0d: valid=%b data=%h ready=%b, want 1 %h %b",
                         c, m_valid, m_data, s_ready, e[c-1], c == 4 || c == 8);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b drain: valid=%b, want 0", m_valid);
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] e [4];
        e[0] = 8'h0A; e[1] = 8'h0B; e[2] = 8'h0C; e[3] = 8'h0D;
        @(negedge clk);
        s_data = 32'h0D0C0B0A; s_valid = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            s_valid = 1'b0; m_ready = 1'b0;
            #1;
            tests++;
            if (m_valid !== 1'b1 || m_data !== 8'h0A || s_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL stall %0d: valid=%b data=%h ready=%b busy=%b, want 1 0a 0 1",
                         c, m_valid, m_data, s_ready, busy);
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            m_ready = 1'b1;
            #1;
            tests++;
            if (m_valid !== 1'b1 || m_data !== e[i] || s_ready !== (i == 3)) begin
                fails++;
                $display("FAIL release chunk %0d: valid=%b data=%h ready=%b, want 1 %h %b",
                         i, m_valid, m_data, s_ready, e[i], i == 3);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b0) begin
            fails++;
            $display("FAIL release drain: valid=%b, want 0", m_valid);
        end
    endtask

    task automatic test_big_endian;
        logic [7:0] e [4];
        e[0] = 8'h44; e[1] = 8'h33; e[2] = 8'h22; e[3] = 8'h11;
        @(negedge clk);
        s_data = 32'h44332211; s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            tests++;
            if (m_valid2 !== 1'b1 || m_data2 !== e[i] || s_ready2 !== (i == 3)) begin
                fails++;
                $display("FAIL big endian chunk %0d: valid=%b data=%h ready=%b, want 1 %h %b",
                         i, m_valid2, m_data2, s_ready2, e[i], i == 3);
            end
        end
        @(negedge clk);
        #1;
        tests++;
        if (m_valid2 !== 1'b0 || busy2 !== 1'b0) begin
            fails++;
            $display("FAIL big endian drain: valid=%b busy=%b, want 0 0", m_valid2, busy2);
        end
    endtask

    task automatic test_reset_mid_word;
        logic [7:0] e [4];
        e[0] = 8'h55; e[1] = 8'h66; e[2] = 8'h77; e[3] = 8'h88;
        @(negedge clk);
        s_data = 32'h44332211; s_valid = 1'b1; m_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            s_valid = 1'b0;
        end
        @(negedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b1 || m_data !== 8'h33) begin
            fails++;
            $display("FAIL pre-reset: valid=%b data=%h, want 1 33", m_valid, m_data);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL async reset: valid=%b busy=%b ready=%b, want 0 0 1", m_valid, busy, s_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s_data = 32'h88776655; s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_valid = 1'b0;
            #1;
            tests++;
            if (m_valid !== 1'b1 || m_data !== e[i]) begin
                fails++;
                $display("FAIL post-reset chunk %0d: valid=%b data=%h, want 1 %h", i, m_valid, m_data, e[i]);
            end
        end
        @(negedge clk);
    endtask

`ifdef STREAM_DOWNSIZER_KEEP_EN
    task automatic test_keep;
        @(negedge clk);
        s_data = 32'h44332211; s_valid = 1'b1; m_ready = 1'b1; s_keep = 4'b1010;
        @(negedge clk);
        s_valid = 1'b0; s_keep = 4'hF;
        #1;
        tests++;
        if (m_valid !== 1'b1 || m_data !== 8'h22 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL keep first: valid=%b data=%h ready=%b, want 1 22 0", m_valid, m_data, s_ready);
        end
        @(negedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b1 || m_data !== 8'h44 || s_ready !== 1'b1) begin
            fails++;
            $display("FAIL keep last: valid=%b data=%h ready=%b, want 1 44 1", m_valid, m_data, s_ready);
        end
        @(negedge clk);
        #1;
        tests++;
        if (m_valid !== 1'b0) begin
            fails++;
            $display("FAIL keep drain: valid=%b, want 0", m_valid);
        end
        s_data = 32'hDEADBEEF; s_valid = 1'b1; s_keep = 4'b0000;
        #1;
        tests++;
        if (s_ready !== 1'b1) begin
            fails++;
            $display("FAIL keep zero ready: ready=%b, want 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0; s_keep = 4'hF;
        #1;
        tests++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL keep zero dropped: valid=%b busy=%b, want 0 0", m_valid, busy);
        end
    endtask
`endif

    initial begin
        tests = 0;
        fails = 0;
        test_reset;
        test_single;
        test_back_to_back;
        test_backpressure;
        test_big_endian;
        test_reset_mid_word;
`ifdef STREAM_DOWNSIZER_KEEP_EN
        test_keep;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
